spm_seq_ctrl: RTL and testbench

//   Sequencer for the bit-serial x parallel multiplier (spm datapath): accepts a signed

---
 rtl/spm_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_spm_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl
//
// Sequencer for a bit-serial x parallel multiplier (spm). It accepts a signed
// SIZE-bit operand pair (in_x, in_y) and holds x on spm_x for the whole
// operation. It streams y into spm_y LSB-first, sign-extended to 2*SIZE bits,
// then a trailing 0. It shifts the serial product returned on spm_p into out_p,
// which ends up holding the 2*SIZE-bit two's-complement product.
//
// Operation: IDLE -> LOAD (1 cycle, spm still cleared) -> RUN (2*SIZE+1 cycles)
//            -> DONE (held until out_ready) -> IDLE.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand pair valid          in_ready   controller can accept
//   in_x       multiplicand (signed)       in_y       multiplier (signed)
//   out_valid  product valid               out_ready  consumer accepts product
//   out_p      product in_x*in_y (signed, 2*SIZE bits)
//   busy       high in LOAD or RUN
//   spm_rst    registered clear to the spm (spm side treats it as async reset)
//   spm_x      registered multiplicand held for the whole operation
//   spm_y      registered serial multiplier bit
//   spm_p      serial product bit from the spm (one cycle latency)
// -----------------------------------------------------------------------------
module spm_seq_ctrl #(
  parameter  int SIZE = 32,
  localparam int CW   = $clog2(2*SIZE+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p,
  output logic              busy,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;   // RUN bit-cycle index c = 0 .. 2*SIZE
  logic [SIZE-1:0] y_sr;    // y, shifted right with sign replication
  logic            run_last;
  logic            run_more_y;

  // Final RUN cycle; a >= compare so a corrupted count can never run past it.
  assign run_last   = (cnt_q >= CW'(2*SIZE));
  // The bit loaded for cycle c+1 is still part of the sign-extended y while
  // c+1 < 2*SIZE; the cycle after that gets a 0.
  assign run_more_y = (cnt_q < CW'(2*SIZE-1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  // NOTE: every output of this block gets a default before the case statement,
  // so a path that does not assign it cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, y serialisation, counter, product deserialiser.
  // NOTE: all registers use non-blocking assignments. Every process then sees
  // pre-edge values, so the order of statements in this block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      y_sr    <= '0;
      spm_x   <= '0;
      spm_y   <= 1'b0;
      spm_rst <= 1'b1;
      out_p   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            spm_x <= in_x;
            y_sr  <= in_y;
            cnt_q <= '0;
          end
        end
        LOAD: begin
          // The spm is still held clear this cycle. Its first y bit becomes
          // valid and the clear is released on the same edge.
          spm_y   <= y_sr[0];
          y_sr    <= {y_sr[SIZE-1], y_sr[SIZE-1:1]};
          spm_rst <= 1'b0;
        end
        RUN: begin
          // spm_p lags spm_y by one cycle, so the sample taken at c=0 is junk.
          if (cnt_q != '0) out_p <= {spm_p, out_p[2*SIZE-1:1]};
          if (run_last) begin
            spm_rst <= 1'b1;
            spm_y   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            spm_y <= run_more_y ? y_sr[0] : 1'b0;
            y_sr  <= {y_sr[SIZE-1], y_sr[SIZE-1:1]};
          end
        end
        default: ;  // DONE: hold everything, out_p stays stable
      endcase
    end
  end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_seq_ctrl
//
// Testbench for spm_seq_ctrl with SIZE=8. A behavioural bit-serial multiplier
// is attached as the spm. The driver pushes the expected product into a
// scoreboard queue when an operand pair is accepted. A monitor on the falling
// edge checks busy and out_valid timing against the accept cycle, and checks
// out_p against the queue head whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_spm_seq_ctrl;

  localparam int SIZE = 8;
  localparam int W    = 2*SIZE;
  localparam int LAT  = 2*SIZE + 2;   // accept edge -> out_valid edge

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_x, in_y;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_p;
  logic            busy;
  logic            spm_rst;
  logic [SIZE-1:0] spm_x;
  logic            spm_y;
  logic            spm_p;

  spm_seq_ctrl #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy),
    .spm_rst  (spm_rst),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_p    (spm_p)
  );

  always #5 clk = ~clk;

  // Behavioural spm: on each edge add x*y_bit to the running sum, emit its
  // LSB (registered, hence one cycle of latency), then shift the sum right.
  longint spm_sum;
  logic   spm_preg;
  longint spm_t;
  always @(posedge clk or posedge spm_rst) begin
    if (spm_rst) begin
      spm_sum  <= 0;
      spm_preg <= 1'b0;
    end else begin
      spm_t     = spm_sum + (spm_y ? longint'($signed(spm_x)) : 64'sd0);
      spm_preg <= spm_t[0];
      spm_sum  <= spm_t >>> 1;
    end
  end
  assign spm_p = spm_preg;

  // Bookkeeping.
  int           cycle = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           active = -1;       // accept-edge cycle of the op in flight
  int           last_accept = -1;
  logic [SIZE-1:0] exp_x;
  logic [W-1:0] sb_q[$];
  bit           started = 1'b0;
  logic         ov_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: timing and scoreboard comparisons, sampled away from the rising edge.
  int diff;
  bit exp_busy, exp_valid;
  always @(negedge clk) begin
    if (started && !rst) begin
      diff      = (active >= 0) ? cycle - active : -1;
      exp_busy  = (diff >= 0) && (diff <= LAT - 1);
      exp_valid = (diff >= LAT);
      check("busy", busy, exp_busy);
      check("out_valid", out_valid, exp_valid);
      if (exp_busy) check("spm_x_held", spm_x, exp_x);
      if (out_valid && !ov_prev && active >= 0) check("latency", cycle - active, LAT);
      ov_prev = out_valid;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_product: got %0h expected none", out_p);
        end else begin
          check("out_p", out_p, sb_q[0]);
          check("in_ready_in_done", in_ready, 1'b0);
          if (out_ready) begin
            void'(sb_q.pop_front());
            active = -1;
          end
        end
      end
    end
  end

  // Present one operand pair and wait (bounded) until it is accepted.
  // gap > 0 also checks the spacing from the previous accept.
  task automatic issue(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                       input bit hold = 1'b0, input int gap = 0);
    bit ok = 1'b0;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(W'(int'($signed(x)) * int'($signed(y))));
      exp_x  = x;
      active = cycle + 1;
      if (gap > 0) check("accept_spacing", active - last_accept, gap);
      last_accept = active;
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until the scoreboard is empty and nothing is in flight.
  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && active < 0) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [SIZE-1:0] rx, ry;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;

    // Reset values.
    #17;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_spm_rst", spm_rst, 1'b1);
    check("rst_spm_x", spm_x, '0);
    check("rst_spm_y", spm_y, 1'b0);
    check("rst_out_p", out_p, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    started   = 1'b1;
    out_ready = 1'b1;

    // 1/2: directed products; expected values 0xF63C, 0x4000, 0x3F01, 0x0000.
    issue(8'd50, -8'sd50);
    drain();
    check("p_50x-50", out_p, 16'hF63C);
    issue(8'h80, 8'h80);
    drain();
    check("p_-128x-128", out_p, 16'h4000);
    issue(8'd127, 8'd127);
    drain();
    check("p_127x127", out_p, 16'h3F01);
    issue(8'd0, 8'hFF);
    drain();
    check("p_0x-1", out_p, 16'h0000);

    // 3: in_valid held, out_ready=1. Accepts are LOAD(1)+RUN(17)+DONE(1)+IDLE(1)
    // = 20 cycles apart.
    issue(8'd5, 8'd9, 1'b1);
    issue(-8'sd3, 8'd100, 1'b1, LAT + 2);
    issue(8'd77, -8'sd2, 1'b0, LAT + 2);
    // in_valid pulse with junk operands while running must be ignored.
    repeat (5) @(posedge clk);
    #1;
    in_x = 8'hAA; in_y = 8'h55; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // 4: backpressure for 10 cycles in DONE; the monitor checks out_p and
    // in_ready on every one of those cycles.
    out_ready = 1'b0;
    issue(-8'sd100, 8'd99);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("stall_reached_done", out_valid, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_out_p", out_p, 16'hD954);   // -100*99 = -9900
    out_ready = 1'b1;
    drain();

    // 5: reset at RUN c=5, then a fresh op.
    issue(8'd10, 8'd20);
    while (cycle < last_accept + 6) @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    active = -1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_spm_rst", spm_rst, 1'b1);
    check("midrst_out_p", out_p, '0);
    @(posedge clk);
    #1;
    check("midrst_next_in_ready", in_ready, 1'b1);
    check("midrst_next_busy", busy, 1'b0);
    check("midrst_next_out_valid", out_valid, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    ov_prev = 1'b0;
    @(posedge clk);
    #1;
    issue(8'd3, -8'sd7);
    drain();
    check("p_3x-7", out_p, 16'hFFEB);

    // 6: random signed pairs against the integer reference.
    for (int i = 0; i < 1500; i++) begin
      rx = SIZE'($urandom);
      ry = SIZE'($urandom);
      issue(rx, ry, 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
